// File: rtl/n4by2_b2_multiplier_seq_if.sv
// ---------------------------------------------------------------------------
// n4by2_b2_multiplier_seq_if
// Operand/result bundle for the sequential multiply-add unit x = q*y + r.
//
// Signals:
//   soc     start of conversion (level), driven by the consumer
//   q       quotient operand, N bits
//   y       divisor operand, M bits
//   r       remainder operand, M bits
//   eoc     end of conversion; 1 = idle or result valid
//   x       result q*y + r, N+M bits
//   bad_rem r >= y seen at the last load (only with CHECK_REMAINDER_EN)
//
// Modports:
//   master  the consumer that issues operands and reads the result
//   slave   the multiply-add unit
//
// Optional feature macro: CHECK_REMAINDER_EN
// ---------------------------------------------------------------------------
interface n4by2_b2_multiplier_seq_if #(
  parameter int N = 4,
  parameter int M = 2
);
  logic           soc;
  logic [N-1:0]   q;
  logic [M-1:0]   y;
  logic [M-1:0]   r;
  logic           eoc;
  logic [N+M-1:0] x;
`ifdef CHECK_REMAINDER_EN
  logic           bad_rem;

  modport master (output soc, q, y, r, input eoc, x, bad_rem);
  modport slave  (input soc, q, y, r, output eoc, x, bad_rem);
`else
  modport master (output soc, q, y, r, input eoc, x);
  modport slave  (input soc, q, y, r, output eoc, x);
`endif
endinterface

// File: rtl/n4by2_b2_multiplier_seq.sv
// ---------------------------------------------------------------------------
// n4by2_b2_multiplier_seq
// Sequential base-2 multiply-add: rebuilds a dividend x = q*y + r from a
// quotient/remainder pair. Shift-and-add, one quotient bit per clock.
//
// Ports:
//   clock   system clock, rising edge
//   reset_  asynchronous active-low reset
//   bus     n4by2_b2_multiplier_seq_if.slave (soc, q, y, r, eoc, x[, bad_rem])
//
// Sequence: IDLE --soc--> CALC (N clocks) --> HOLD --!soc--> IDLE.
// eoc is 1 in IDLE and HOLD; x changes only on the completion edge.
//
// Optional feature macro: CHECK_REMAINDER_EN
//   When defined, bad_rem is registered as (r >= y) at every load edge.
// ---------------------------------------------------------------------------
module n4by2_b2_multiplier_seq #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic                          clock,
  input  logic                          reset_,
  n4by2_b2_multiplier_seq_if.slave      bus
);

  localparam int W  = N + M;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [N-1:0]    qreg_reg;
  logic [W-1:0]    acc_reg;
  logic [W-1:0]    mcand_reg;
  logic [W-1:0]    x_reg;
  logic [CW-1:0]   cnt_reg;

  logic            eoc;
  logic            load;
  logic            last_step;
  logic [W-1:0]    acc_step;

  // Accumulator value after the current CALC step. The widest possible sum
  // still fits in W bits, so no carry-out is kept.
  assign acc_step = acc_reg + (qreg_reg[0] ? mcand_reg : '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (bus.soc)   state_next = CALC;
      CALC: if (last_step) state_next = HOLD;
      // A soc still held from the previous load must not restart the unit.
      HOLD: if (!bus.soc)  state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    eoc       = 1'b1;
    load      = 1'b0;
    last_step = 1'b0;
    unique case (state_reg)
      IDLE: load = bus.soc;
      CALC: begin
        eoc       = 1'b0;
        // cnt is the number of steps still to run including this one.
        last_step = (cnt_reg == CW'(1));
      end
      HOLD: ;
      default: ;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      qreg_reg  <= '0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      cnt_reg   <= '0;
      x_reg     <= '0;
    end else if (load) begin
      qreg_reg  <= bus.q;
      acc_reg   <= W'(bus.r);
      mcand_reg <= W'(bus.y);
      cnt_reg   <= CW'(N);
    end else if (state_reg == CALC) begin
      acc_reg   <= acc_step;
      mcand_reg <= mcand_reg << 1;
      qreg_reg  <= qreg_reg >> 1;
      cnt_reg   <= cnt_reg - CW'(1);
      if (last_step) begin
        x_reg <= acc_step;
      end
    end
  end

  assign bus.eoc = eoc;
  assign bus.x   = x_reg;

`ifdef CHECK_REMAINDER_EN
  logic bad_rem_reg;

  // A valid division result always has r < y; y = 0 therefore always flags.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      bad_rem_reg <= 1'b0;
    end else if (load) begin
      bad_rem_reg <= (bus.r >= bus.y);
    end
  end

  assign bus.bad_rem = bad_rem_reg;
`endif

endmodule

// File: tb/tb_n4by2_b2_multiplier_seq.sv
// ---------------------------------------------------------------------------
// tb_n4by2_b2_multiplier_seq
// Scoreboard bench for n4by2_b2_multiplier_seq. The driver pushes the
// arithmetic expectation (q*y + r, r >= y) for every issued operation; a
// separate monitor pops and compares whenever eoc rises.
// ---------------------------------------------------------------------------
module tb_n4by2_b2_multiplier_seq;

  localparam int N = 4;
  localparam int M = 2;
  localparam int W = N + M;

  typedef struct {
    int unsigned x;
    bit          br;
    int unsigned q;
    int unsigned y;
    int unsigned r;
  } exp_t;

  logic clock;
  logic reset_;
  int   checks;
  int   errors;
  exp_t sb[$];
  bit   drv_done;

  n4by2_b2_multiplier_seq_if #(.N(N), .M(M)) bus ();

  n4by2_b2_multiplier_seq #(.N(N), .M(M)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic from the operand values.
  function automatic exp_t model(input int unsigned q, input int unsigned y,
                                 input int unsigned r);
    exp_t e;
    e.x  = q * y + r;
    e.br = (r >= y);
    e.q  = q;
    e.y  = y;
    e.r  = r;
    return e;
  endfunction

  // ---------------- Monitor ----------------
  initial begin : monitor
    logic prev_eoc;
    exp_t e;
    prev_eoc = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset_) begin
        prev_eoc = 1'b1;
      end else begin
        if (!prev_eoc && bus.eoc === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("result_x", longint'(bus.x), longint'(e.x));
`ifdef CHECK_REMAINDER_EN
            chk("bad_rem", longint'(bus.bad_rem), longint'(e.br));
`endif
            $display("op q=%0d y=%0d r=%0d -> x=%0d (exp %0d)",
                     e.q, e.y, e.r, bus.x, e.x);
          end
        end
        prev_eoc = bus.eoc;
      end
    end
  end

  // One full operation from IDLE back to IDLE. Called #1 after a rising edge
  // with the unit in IDLE. Operands are scrambled every clock while busy.
  task automatic do_op(input int unsigned q, input int unsigned y,
                       input int unsigned r, input int hold);
    exp_t e;
    int   n;
    e = model(q, y, r);
    bus.q   = N'(q);
    bus.y   = M'(y);
    bus.r   = M'(r);
    bus.soc = 1'b1;
    sb.push_back(e);
    @(posedge clock); #1;
    chk("eoc_fall", longint'(bus.eoc), 0);
    n = 0;
    while (bus.eoc !== 1'b1 && n < 20) begin
      bus.q = N'($urandom);
      bus.y = M'($urandom);
      bus.r = M'($urandom);
      if (hold == 0) bus.soc = 1'($urandom);
      @(posedge clock); #1;
      n++;
    end
    chk("latency", n, N);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("hold_eoc", longint'(bus.eoc), 1);
      chk("hold_x", longint'(bus.x), longint'(e.x));
    end
    bus.soc = 1'b0;
    @(posedge clock); #1;
    chk("idle_x", longint'(bus.x), longint'(e.x));
  endtask

  // ---------------- Driver ----------------
  initial begin : driver
    drv_done = 1'b0;
    checks = 0;
    errors = 0;
    reset_  = 1'b0;
    bus.soc = 1'b1;  // soc during reset must not start anything
    bus.q = '0; bus.y = '0; bus.r = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_eoc", longint'(bus.eoc), 1);
    chk("reset_x", longint'(bus.x), 0);
`ifdef CHECK_REMAINDER_EN
    chk("reset_bad_rem", longint'(bus.bad_rem), 0);
`endif
    bus.soc = 1'b0;
    reset_  = 1'b1;
    @(posedge clock); #1;
    chk("idle_eoc", longint'(bus.eoc), 1);

    // Directed cases
    do_op(3, 2, 1, 0);
    do_op(15, 3, 2, 0);
    do_op(5, 0, 0, 0);
    do_op(5, 0, 1, 0);
    do_op(5, 3, 2, 0);
    // Held soc: exactly one computation, then a fresh load after soc drops.
    do_op(9, 2, 1, 10);
    do_op(12, 1, 0, 1);

    // Reset during CALC aborts the operation.
    bus.q = 4'd15; bus.y = 2'd3; bus.r = 2'd1; bus.soc = 1'b1;
    @(posedge clock); #1;          // load edge
    @(posedge clock);              // 1st CALC edge
    @(posedge clock); #1;          // 2nd CALC edge
    reset_ = 1'b0;
    bus.soc = 1'b0;
    #1;
    chk("abort_eoc", longint'(bus.eoc), 1);
    chk("abort_x", longint'(bus.x), 0);
`ifdef CHECK_REMAINDER_EN
    chk("abort_bad_rem", longint'(bus.bad_rem), 0);
`endif
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_ = 1'b1;
    @(posedge clock); #1;
    chk("post_abort_eoc", longint'(bus.eoc), 1);
    do_op(7, 3, 2, 0);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      do_op($urandom_range(0, 15), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    drv_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin : watchdog
    #200000;
    if (!drv_done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
    end
  end

endmodule

// File: doc/n4by2_b2_multiplier_seq.md
# n4by2_b2_multiplier_seq

Sequential base-2 multiply-add unit that rebuilds a dividend from a division result: x = q·y + r. It is the inverse companion of the 4-by-2 base-2 divider. It is used to check divider outputs and to reconstruct dividends in datapaths that store quotient/remainder pairs. Shift-and-add, one quotient bit per clock, with a soc/eoc handshake.

## Interface
Parameters:
- N, 4, quotient width (q digits)
- M, 2, divisor and remainder width (y, r digits)

Ports:
- clock  input  1  system clock, rising edge
- reset_  input  1  asynchronous, active-low reset
- soc  input  1  start of conversion, level, from consumer
- q  input  N  quotient operand
- y  input  M  divisor operand
- r  input  M  remainder operand
- eoc  output  1  end of conversion; 1 = idle or result valid
- x  output  N+M  result q·y + r, registered
- bad_rem  output  1  r ≥ y detected on the last load; exists only with CHECK_REMAINDER_EN

One clock; reset is asynchronous and active-low (reset_).

## Operation
- States: IDLE, CALC, HOLD.
- IDLE: eoc=1. When soc=1 is sampled at a rising edge:
  - q, y and r are latched into internal registers.
  - acc ← zero-extended r; mcand ← zero-extended y; cnt ← N.
  - The state moves to CALC.
- CALC: eoc=0. Each edge does the following:
  - if qreg[0]=1 then acc ← acc + mcand;
  - mcand ← mcand<<1; qreg ← qreg>>1; cnt ← cnt−1.
  - At the edge where cnt reaches 0, x ← final acc and the state moves to HOLD.
- HOLD: eoc=1 and x is valid. The block stays in HOLD while soc=1. soc=0 moves it to IDLE, so a held soc never restarts the unit.
- Operands are sampled only at the load edge. Changes on q, y or r during CALC or HOLD are ignored.
- Arithmetic widths:
  - acc and mcand are N+M bits wide.
  - The maximum result is (2^N−1)(2^M−1) + (2^M−1) < 2^(N+M), so no overflow occurs and no carry-out exists.
- y=0 is legal: x = r.
- x keeps its previous value during CALC and changes only at the completion edge.
- soc is ignored in CALC.

## Timing
- Reset values (reset_=0, asynchronous): state=IDLE, eoc=1, x=0, bad_rem=0. The internal registers are cleared.
- Latency: soc is sampled at edge t0. eoc falls after t0. x and eoc=1 become valid after edge t0+N, which is N clocks from the load.
- Throughput: one operation per N+2 clocks minimum (load, N steps, one IDLE cycle after soc drops).
- The consumer drives soc high in IDLE, drops it after seeing eoc=0 or in HOLD, and reads x while eoc=1.
- A reset during CALC aborts immediately. The partial result is discarded, x=0 and eoc=1.
- Simultaneous reset_ assertion and soc: reset wins.

## Configuration
- CHECK_REMAINDER_EN defined:
  - At the load edge, bad_rem ← (r ≥ y). This flags an inconsistent division result, including any r with y=0.
  - bad_rem is held until the next load or reset.
  - x is still computed normally.
- CHECK_REMAINDER_EN not defined:
  - The bad_rem port and the comparator are absent.
  - Behaviour is otherwise identical.

## Test plan
- Reset, then q=4'b0011, y=2'b10, r=2'b01, soc=1 for one load edge -> eoc=0 for 4 clocks, then x=6'd7 and eoc=1 at t0+4.
- q=15, y=3, r=2 -> x=47 (maximum in-range value, no wrap).
- q=5, y=0, r=0 -> x=0. With CHECK_REMAINDER_EN: q=5, y=0, r=1 -> x=1 and bad_rem=1. q=5, y=3, r=2 -> bad_rem=0.
- soc held high for 10 clocks after one load -> exactly one computation, stays in HOLD with x stable. After soc=0 then soc=1 -> new load.
- Change q, y and r every clock during CALC -> x equals the result for the operands present at the load edge.
- Assert reset_=0 at the 2nd CALC edge -> x=0 and eoc=1 immediately (asynchronous). After release, the next soc produces a correct result.
